// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the ALU command issuer slice.
//   ALU_W / RES_W   operand and result widths
//   alu_op_e        defined ALU op codes (101-111 reserved)
//   cmd_t           one queued command {op, a, b} (35 bits)
//   issuer_state_e  issuer FSM states
//   is_reserved_op  flags op codes the ALU treats as ADD
package alu_pkg;

  localparam int unsigned ALU_W = 16;
  localparam int unsigned RES_W = 17;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } alu_op_e;

  // Op is kept as raw bits so reserved codes pass through unchanged.
  typedef struct packed {
    logic [2:0]       op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } issuer_state_e;

  function automatic logic is_reserved_op(input logic [2:0] op);
    return op > 3'b100;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command, ALU and response signals of the issuer.
//   cmd_*  valid/ready command input (source -> issuer)
//   alu_*  registered operands/op out, combinational result in
//   res_*  valid/ready response output (issuer -> consumer)
// master: issuer side; slave: environment (source, ALU, consumer).
interface alu_cmd_issuer_if;
  import alu_pkg::*;

  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [2:0]       cmd_op_i;
  logic [ALU_W-1:0] cmd_a_i;
  logic [ALU_W-1:0] cmd_b_i;

  logic [ALU_W-1:0] alu_a_o;
  logic [ALU_W-1:0] alu_b_o;
  logic [2:0]       alu_ctrl_o;
  logic [RES_W-1:0] alu_c_i;

  logic             res_valid_o;
  logic             res_ready_i;
  logic [RES_W-1:0] res_data_o;
  logic [2:0]       res_op_o;
  logic             res_zero_o;
  logic             res_err_o;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, alu_c_i, res_ready_i,
    output cmd_ready_o, alu_a_o, alu_b_o, alu_ctrl_o,
           res_valid_o, res_data_o, res_op_o, res_zero_o, res_err_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, alu_c_i, res_ready_i,
    input  cmd_ready_o, alu_a_o, alu_b_o, alu_ctrl_o,
           res_valid_o, res_data_o, res_op_o, res_zero_o, res_err_o
  );

endinterface

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous DEPTH-entry command FIFO (DEPTH power of two, >= 2).
//   clk_i, rst_i   clock, async active-high reset (empties the FIFO)
//   push_i, din_i  write request and data (ignored when full)
//   pop_i          read request (ignored when empty)
//   dout_o         head entry, valid while !empty_o
//   full_o, empty_o
module cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  cmd_t din_i,
  input  logic pop_i,
  output cmd_t dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din_i;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, issues them to an external
// combinational ALU from registered operands, and holds each result in a
// response register until the consumer takes it.
//   clk_i, rst_i  clock, async active-high reset (drops all queued work)
//   bus           alu_cmd_issuer_if.master: cmd_* in, alu_* to/from ALU,
//                 res_* out
//   DEPTH         command FIFO entries
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_cmd_issuer_if.master bus
);

  issuer_state_e state_q;
  issuer_state_e state_d;
  cmd_t          din;
  cmd_t          head;
  logic          full;
  logic          empty;
  logic          push;
  logic          load;
  logic          capture;
  logic          consume;

  always_comb begin
    din    = '0;
    din.op = bus.cmd_op_i;
    din.a  = bus.cmd_a_i;
    din.b  = bus.cmd_b_i;
  end

  assign push            = bus.cmd_valid_i && !full;
  assign bus.cmd_ready_o = !full;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (load),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // load pops the head into the operand registers; consuming a result with
  // work pending loads the next command on the same edge.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready_i) begin
          consume = 1'b1;
          if (!empty) begin
            load    = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.alu_a_o     <= '0;
      bus.alu_b_o     <= '0;
      bus.alu_ctrl_o  <= '0;
      bus.res_valid_o <= 1'b0;
      bus.res_data_o  <= '0;
      bus.res_op_o    <= '0;
      bus.res_zero_o  <= 1'b0;
      bus.res_err_o   <= 1'b0;
    end else begin
      if (load) begin
        bus.alu_a_o    <= head.a;
        bus.alu_b_o    <= head.b;
        bus.alu_ctrl_o <= head.op;
      end
      if (capture) begin
        bus.res_valid_o <= 1'b1;
        bus.res_data_o  <= bus.alu_c_i;
        bus.res_op_o    <= bus.alu_ctrl_o;
        bus.res_zero_o  <= (bus.alu_c_i[ALU_W-1:0] == '0);
        bus.res_err_o   <= is_reserved_op(bus.alu_ctrl_o);
      end else if (consume) begin
        bus.res_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed bench for alu_cmd_issuer with a behavioural
// ALU and a scoreboard of expected responses checked on each consumption.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  typedef struct packed {
    logic [16:0] data;
    logic [2:0]  op;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_cmd_issuer_if bus ();

  alu_cmd_issuer #(.DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Behavioural ALU: reserved codes execute as ADD.
  always_comb begin
    case (bus.alu_ctrl_o)
      3'b001:  bus.alu_c_i = {1'b0, bus.alu_a_o} - {1'b0, bus.alu_b_o};
      3'b010:  bus.alu_c_i = {1'b0, bus.alu_a_o & bus.alu_b_o};
      3'b011:  bus.alu_c_i = {1'b0, bus.alu_a_o | bus.alu_b_o};
      3'b100:  bus.alu_c_i = {1'b0, bus.alu_a_o ^ bus.alu_b_o};
      default: bus.alu_c_i = {1'b0, bus.alu_a_o} + {1'b0, bus.alu_b_o};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one command (bounded wait for ready) and record its expected result.
  task automatic send(input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [16:0] data);
    exp_t e;
    for (int i = 0; i < 50 && !bus.cmd_ready_o; i++) tick();
    chk("cmd_ready_wait", {31'd0, bus.cmd_ready_o}, 32'd1);
    bus.cmd_op_i    = op;
    bus.cmd_a_i     = a;
    bus.cmd_b_i     = b;
    bus.cmd_valid_i = 1'b1;
    e.data = data;
    e.op   = op;
    e.zero = (data[15:0] == 16'h0000);
    e.err  = (op > 3'b100);
    sb.push_back(e);
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || bus.res_valid_o) && n < 100) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready_o}, 32'd1);
    chk({tag, "_res_valid"}, {31'd0, bus.res_valid_o}, 32'd0);
    chk({tag, "_res_data"},  {15'd0, bus.res_data_o}, 32'd0);
    chk({tag, "_res_op"},    {29'd0, bus.res_op_o}, 32'd0);
    chk({tag, "_res_flags"}, {30'd0, bus.res_zero_o, bus.res_err_o}, 32'd0);
    chk({tag, "_alu_ab"},    {bus.alu_a_o, bus.alu_b_o}, 32'd0);
    chk({tag, "_alu_ctrl"},  {29'd0, bus.alu_ctrl_o}, 32'd0);
  endtask

  // Scoreboard: compare each result as it is taken by the consumer.
  always @(negedge clk) begin
    if (!rst && bus.res_valid_o && bus.res_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_res", {31'd0, bus.res_valid_o}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("res_data", {15'd0, bus.res_data_o}, {15'd0, mon_e.data});
        chk("res_op",   {29'd0, bus.res_op_o},   {29'd0, mon_e.op});
        chk("res_zero", {31'd0, bus.res_zero_o}, {31'd0, mon_e.zero});
        chk("res_err",  {31'd0, bus.res_err_o},  {31'd0, mon_e.err});
      end
    end
  end

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = '0;
    bus.cmd_a_i     = '0;
    bus.cmd_b_i     = '0;
    bus.res_ready_i = 1'b0;
    #1 rst = 1'b1;
    #2 check_reset("por");
    tick();
    tick();
    rst = 1'b0;

    // Single ADD: latency from acceptance edge to res_valid is 2 cycles.
    bus.res_ready_i = 1'b1;
    send(OP_ADD, 16'h0005, 16'h0003, 17'h00008);
    chk("lat_e0_valid", {31'd0, bus.res_valid_o}, 32'd0);
    tick();
    chk("lat_e1_valid", {31'd0, bus.res_valid_o}, 32'd0);
    chk("issue_ab", {bus.alu_a_o, bus.alu_b_o}, 32'h0005_0003);
    chk("issue_ctrl", {29'd0, bus.alu_ctrl_o}, 32'd0);
    tick();
    chk("lat_e2_valid", {31'd0, bus.res_valid_o}, 32'd1);
    wait_drain();

    // Carry out and SUB borrow.
    send(OP_ADD, 16'hFFFF, 16'h0001, 17'h10000);
    send(OP_SUB, 16'h0003, 16'h0005, 17'h1FFFE);
    wait_drain();

    // Fill: 1 in flight + 4 queued, then hold and release.
    bus.res_ready_i = 1'b0;
    send(OP_ADD, 16'h1000, 16'h0234, 17'h01234);
    send(OP_SUB, 16'h0000, 16'h0001, 17'h1FFFF);
    send(OP_OR,  16'h00F0, 16'h0F00, 17'h00FF0);
    send(OP_AND, 16'hFFFF, 16'h8001, 17'h08001);
    send(OP_XOR, 16'h1234, 16'h00FF, 17'h012CB);
    chk("full_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_valid", {31'd0, bus.res_valid_o}, 32'd1);
      chk("hold_data", {15'd0, bus.res_data_o}, 32'h01234);
    end
    bus.res_ready_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("gap_valid", {31'd0, bus.res_valid_o},
          {31'd0, (k % 2 == 0) && (k <= 8)});
    end
    chk("drained_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    wait_drain();

    // Reserved op executes as ADD, flagged.
    send(3'b110, 16'h0002, 16'h0002, 17'h00004);
    wait_drain();

    // Asynchronous reset while holding a result with 2 queued.
    bus.res_ready_i = 1'b0;
    send(OP_ADD, 16'h0001, 16'h0001, 17'h00002);
    send(OP_ADD, 16'h0002, 16'h0002, 17'h00004);
    send(OP_ADD, 16'h0003, 16'h0003, 17'h00006);
    chk("pre_rst_valid", {31'd0, bus.res_valid_o}, 32'd1);
    chk("pre_rst_count", 32'(dut.u_fifo.count), 32'd2);
    #2 rst = 1'b1;
    #1 check_reset("mid_rst");
    sb.delete();
    tick();
    rst = 1'b0;
    bus.res_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_valid", {31'd0, bus.res_valid_o}, 32'd0);
    end
    chk("post_rst_count", 32'(dut.u_fifo.count), 32'd0);

    // Simultaneous push and pop at count 2.
    bus.res_ready_i = 1'b0;
    send(OP_AND, 16'hF0F0, 16'h0FF0, 17'h000F0);
    send(OP_XOR, 16'hAAAA, 16'hAAAA, 17'h00000);
    send(OP_ADD, 16'h0007, 16'h0008, 17'h0000F);
    chk("pp_count_before", 32'(dut.u_fifo.count), 32'd2);
    bus.res_ready_i = 1'b1;
    send(OP_SUB, 16'h8000, 16'h0001, 17'h07FFF);
    chk("pp_count_after", 32'(dut.u_fifo.count), 32'd2);
    chk("pp_issue_ctrl", {29'd0, bus.alu_ctrl_o}, {29'd0, OP_XOR});
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Sequential command front-end for the 16-bit combinational ALU. It accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. It issues each request to the ALU from registered operand/control outputs, then captures the 17-bit result into a response register held under a second valid/ready handshake. It sits between the command source (sequencer or testbench driver) and the ALU, and is the initiator side of the ALU's operand/result interface.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  FIFO can accept; equals !full.
- cmd_op_i  in  3  ALU op code.
- cmd_a_i, cmd_b_i  in  16 each  operands.
- alu_a_o, alu_b_o  out  16 each  registered operands to ALU.
- alu_ctrl_o  out  3  registered op to ALU.
- alu_c_i  in  17  combinational ALU result.
- res_valid_o  out  1  result held.
- res_ready_i  in  1  consumer takes result.
- res_data_o  out  17  captured result.
- res_op_o  out  3  op that produced it.
- res_zero_o  out  1  res_data_o[15:0] == 0.
- res_err_o  out  1  op code was reserved (101–111).

## Operation
- Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; 101–111 reserved. Reserved codes are accepted and forwarded unchanged, and set res_err_o; the ALU executes them as ADD.
- Push when cmd_valid_i && cmd_ready_o. Pop only on FSM issue.
- Push and pop in the same cycle are legal; count is unchanged. No push when full, so there is no write-through.
- FSM states:
  - IDLE: if FIFO non-empty → EXEC; load alu_*_o from the FIFO head and pop.
  - EXEC: unconditionally → RESP; capture alu_c_i, alu_ctrl_o, zero and err into res_* and set res_valid_o.
  - RESP: hold all res_* stable while !res_ready_i.
    - On res_ready_i with FIFO non-empty → EXEC; load and pop the next head in the same edge (back-to-back).
    - On res_ready_i with FIFO empty → IDLE; clear res_valid_o.
- alu_*_o change only on a load edge and otherwise hold their last value.
- Width rules: result is full 17 bits from the ALU, not re-derived.
  - SUB borrow appears as bit 16 of two's-complement 17-bit wrap, e.g. 3−5 = 0x1FFFE.
  - Logic ops return bit 16 = 0.
- Reset at any point, including mid-EXEC or mid-RESP:
  - FIFO empties; state goes to IDLE.
  - All outputs go to 0, except cmd_ready_o = 1.
  - In-flight commands are dropped.

## Timing
- Acceptance edge E0: entry visible at the head after E0.
- E1: IDLE loads alu_*_o and pops.
- E2: result captured; res_valid_o = 1 after E2.
- Acceptance-to-valid latency: 2 cycles.
- Back-to-back: a consumed result at edge Ek with the FIFO non-empty gives the next res_valid_o after Ek+1.
  - res_valid_o deasserts for exactly one cycle between results.
  - Peak throughput: 1 result / 2 cycles.
- cmd_ready_o is combinational from count and drops in the cycle after the push that fills the FIFO.
- res_* are registered; no combinational path from res_ready_i to any output.

## Structure
- Shared package alu_pkg:
  - alu_op_e enum (ADD/SUB/AND/OR/XOR codes above).
  - ALU_W = 16, RES_W = 17.
  - issuer state enum (IDLE, EXEC, RESP).
  - is_reserved_op() function.
- Sub-module cmd_fifo: synchronous FIFO, DEPTH×35 bits (op, a, b); wrapping pointers plus count of width $clog2(DEPTH+1); full/empty flags.
- Top: FSM, ALU operand registers, response register.
- The ALU is instantiated outside the issuer.

## Test plan
- ADD 0x0005 + 0x0003, res_ready_i = 1 → res_valid_o 2 cycles after accept; res_data_o = 0x00008, res_zero_o = 0, res_err_o = 0.
- ADD 0xFFFF + 0x0001 → res_data_o = 0x10000, res_zero_o = 1. SUB 0x0003 − 0x0005 → 0x1FFFE.
- Five commands pushed with res_ready_i = 0:
  - cmd_ready_o low after the 4th FIFO entry plus 1 in flight.
  - Holding res_ready_i low keeps res_data_o stable.
  - Releasing it drains the commands in order with one-cycle valid gaps.
- Op 110 with a = 0x0002, b = 0x0002 → res_op_o = 110, res_err_o = 1, res_data_o = 0x00004.
- Assert rst_i during RESP with 2 queued → all outputs 0 immediately (asynchronously), cmd_ready_o = 1, and no result after deassertion.
- Simultaneous push and pop at count 2 → count stays 2, order preserved, with AND 0xF0F0 & 0x0FF0 = 0x000F0 and XOR 0xAAAA ^ 0xAAAA = 0x00000 (zero = 1).
